// File: rtl/gamma_sequencer.sv
// Sequencer for one gamma cycle of a temporal operator: it pulses the operator
// latch, drives rising-edge-coded operands, and captures the first op_y rise.
module gamma_sequencer #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int TIME_W            = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [TIME_W-1:0] a_time,
  input  logic [TIME_W-1:0] b_time,
  input  logic              a_inf,
  input  logic              b_inf,
  output logic              op_set,
  output logic              op_a,
  output logic              op_b,
  input  logic              op_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [TIME_W-1:0] res_time,
  output logic              res_inf,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; start_ready is high only in IDLE, res_valid only in DONE.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SET  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Counter wide enough for 256-clock windows and for comparing any operand time.
  localparam int CW = (TIME_W > 8) ? TIME_W + 1 : 9;
  localparam logic [CW-1:0] PW_LAST  = CW'(PULSE_WIDTH - 1);
  localparam logic [CW-1:0] GCW_LAST = CW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [CW-1:0] GCW_C    = CW'(GAMMA_CYCLE_WIDTH);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [TIME_W-1:0] a_q, b_q;
  logic              a_inf_q, b_inf_q;
  logic              captured;
  logic [CW-1:0]     a_ext, b_ext;

  assign a_ext = {{(CW-TIME_W){1'b0}}, a_q};
  assign b_ext = {{(CW-TIME_W){1'b0}}, b_q};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_valid)     state_nxt = S_SET;
      S_SET:  if (cnt == PW_LAST)  state_nxt = S_RUN;
      S_RUN:  if (cnt == GCW_LAST) state_nxt = S_DONE;
      S_DONE: if (res_ready)       state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  // Operator-facing strobes are decoded only from registered state and latches.
  always_comb begin
    start_ready = 1'b0;
    res_valid   = 1'b0;
    op_set      = 1'b0;
    op_a        = 1'b0;
    op_b        = 1'b0;
    case (state)
      S_IDLE: start_ready = 1'b1;
      S_SET:  op_set      = 1'b1;
      S_RUN: begin
        op_a = !a_inf_q && (cnt >= a_ext);
        op_b = !b_inf_q && (cnt >= b_ext);
      end
      S_DONE: res_valid = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      a_inf_q  <= 1'b0;
      b_inf_q  <= 1'b0;
      captured <= 1'b0;
      res_time <= '0;
      res_inf  <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || (state == S_IDLE) || (state == S_DONE))
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);

      if (state == S_IDLE && start_valid) begin
        a_q      <= a_time;
        b_q      <= b_time;
        // Times that can never be reached inside the window behave as no spike.
        a_inf_q  <= a_inf || ({{(CW-TIME_W){1'b0}}, a_time} >= GCW_C);
        b_inf_q  <= b_inf || ({{(CW-TIME_W){1'b0}}, b_time} >= GCW_C);
        captured <= 1'b0;
        res_time <= '0;
        res_inf  <= 1'b0;
      end

      if (state == S_RUN) begin
        if (op_y && !captured) begin
          res_time <= cnt[TIME_W-1:0];
          captured <= 1'b1;
        end
        if (cnt == GCW_LAST)
          res_inf <= !(captured || op_y);
      end
    end
  end

endmodule

// File: tb/tb_gamma_sequencer.sv
// Bench for gamma_sequencer: directed scenarios plus random runs, with a
// behavioural operator model and a queue-based scoreboard.
module tb_gamma_sequencer;
  localparam int GCW = 16;
  localparam int PW  = 8;
  localparam int TW  = 4;
  localparam int INF = 1000;

  logic          clk, rst_n;
  logic          start_valid, start_ready;
  logic [TW-1:0] a_time, b_time;
  logic          a_inf, b_inf;
  logic          op_set, op_a, op_b, op_y;
  logic          res_valid, res_ready;
  logic [TW-1:0] res_time;
  logic          res_inf;
  logic [1:0]    dbg_state;

  gamma_sequencer #(.GAMMA_CYCLE_WIDTH(GCW), .PULSE_WIDTH(PW), .TIME_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .a_time(a_time), .b_time(b_time), .a_inf(a_inf), .b_inf(b_inf),
    .op_set(op_set), .op_a(op_a), .op_b(op_b), .op_y(op_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_time(res_time),
    .res_inf(res_inf), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- operator model: 0 = xor/not-equal, 1 = min (or), 2 = max (and)
  int   op_sel = 0;
  logic inj = 1'b0;
  assign op_y = inj | ((op_sel == 0) ? (op_a ^ op_b) :
                       (op_sel == 1) ? (op_a | op_b) : (op_a & op_b));

  // ---------------- scoreboard state ----------------
  logic [TW:0] exp_q[$];
  bit          act = 1'b0;
  int          acc, cur_ta, cur_tb;
  int          checks = 0, errors = 0;
  int          rdy_mode = 2;  // 0 random, 1 held low, 2 held high

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int eff(int t, bit inf);
    return (inf || t >= GCW) ? INF : t;
  endfunction

  // First window index at which the operator output would be high.
  function automatic logic [TW:0] ref_result(int ta, int tb, int op);
    for (int k = 0; k < GCW; k++) begin
      bit fa = (k >= ta);
      bit fb = (k >= tb);
      bit y  = (op == 0) ? (fa != fb) : (op == 1) ? (fa | fb) : (fa & fb);
      if (y) return {1'b0, TW'(k)};
    end
    return {1'b1, TW'(0)};
  endfunction

  // ---------------- res_ready driver ----------------
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      res_ready = (rdy_mode == 0) ? 1'($urandom_range(0, 1)) : (rdy_mode == 2);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int j;
    logic es, ea, eb, ev;
    logic [TW:0] e;
    if (rst_n) begin
      es = 0; ea = 0; eb = 0; ev = 0;
      if (act) begin
        j = cyc - acc;
        if (j < PW) es = 1;
        else if (j < PW + GCW) begin
          ea = ((j - PW) >= cur_ta);
          eb = ((j - PW) >= cur_tb);
        end else ev = 1;
      end
      chk("start_ready", int'(start_ready), int'(!act));
      chk("op_set", int'(op_set), int'(es));
      chk("op_a", int'(op_a), int'(ea));
      chk("op_b", int'(op_b), int'(eb));
      chk("res_valid", int'(res_valid), int'(ev));
      if (res_valid && ev && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("res_time", int'(res_time), int'(e[TW-1:0]));
        chk("res_inf", int'(res_inf), int'(e[TW]));
        if (res_ready) begin
          void'(exp_q.pop_front());
          act = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(int at, int bt, bit ai, bit bi, int op);
    int n = 0;
    @(negedge clk); #1;
    while (!start_ready && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    if (!start_ready) begin
      chk("start_timeout", 0, 1);
      return;
    end
    op_sel = op;
    a_time = TW'(at);
    b_time = TW'(bt);
    a_inf = ai;
    b_inf = bi;
    start_valid = 1'b1;
    cur_ta = eff(at, ai);
    cur_tb = eff(bt, bi);
    exp_q.push_back(ref_result(cur_ta, cur_tb, op));
    acc = cyc + 1;
    act = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (act && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (act) begin
      chk("done_timeout", 0, 1);
      act = 1'b0;
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    start_valid = 0; a_time = 0; b_time = 0; a_inf = 0; b_inf = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", int'(dbg_state), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_op_set", int'(op_set), 0);
    chk("rst_res_time", int'(res_time), 0);
    chk("rst_res_inf", int'(res_inf), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // xor operator, a=3 b=7 -> 3; accepted on first edge after reset release
    do_start(3, 7, 0, 0, 0);
    chk("first_accept_cycle", acc, cyc);
    wait_idle();
    do_start(5, 5, 0, 0, 0);      // equal times -> no edge
    wait_idle();
    do_start(0, 15, 1, 0, 1);     // a inf, b at last window slot
    wait_idle();
    do_start(0, 0, 0, 0, 2);      // both at k=0
    wait_idle();
    do_start(0, 0, 1, 1, 1);      // both inf
    wait_idle();

    // op_y glitch during SET must be ignored
    do_start(2, 9, 0, 0, 2);
    @(negedge clk); #1; inj = 1'b1;
    repeat (3) @(negedge clk);
    #1; inj = 1'b0;
    wait_idle();

    // consumer stalls in DONE; extra starts must not be queued
    rdy_mode = 1;
    do_start(4, 1, 0, 0, 0);
    n = 0;
    while ((cyc - acc) < PW + GCW && n < 100) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      start_valid = i[0];
    end
    start_valid = 1'b0;
    rdy_mode = 2;
    wait_idle();
    repeat (3) @(negedge clk);

    // reset during RUN at k=4 aborts the cycle
    do_start(6, 2, 0, 0, 1);
    n = 0;
    do begin @(negedge clk); n++; end while ((cyc - acc) != PW + 4 && n < 100);
    #2;
    rst_n = 1'b0;
    act = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_op_set", int'(op_set), 0);
    chk("arst_op_a", int'(op_a), 0);
    chk("arst_op_b", int'(op_b), 0);
    chk("arst_res_valid", int'(res_valid), 0);
    chk("arst_res_time", int'(res_time), 0);
    chk("arst_state", int'(dbg_state), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_start(6, 2, 0, 0, 1);
    wait_idle();

    // random traffic with a randomly stalling consumer
    rdy_mode = 0;
    for (int i = 0; i < 40; i++) begin
      do_start($urandom_range(0, 15), $urandom_range(0, 15),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
               $urandom_range(0, 2));
    end
    wait_idle();
    rdy_mode = 2;
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL global_timeout got %0d expected 0", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gamma_sequencer.md
GAMMA_SEQUENCER -- requirements
Module: gamma_sequencer

Interface
REQ-001 SHALL have parameter GAMMA_CYCLE_WIDTH, default 16: clocks in the RUN window; legal range 2..256.
REQ-002 SHALL have parameter PULSE_WIDTH, default 8: clocks op_set is held high; legal range 1..256.
REQ-003 SHALL have parameter TIME_W, default 4: spike-time width; 2**TIME_W >= GAMMA_CYCLE_WIDTH.
REQ-004 SHALL have port clk  in  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_valid  in  1  request to run one gamma cycle.
REQ-007 SHALL have port start_ready  out  1  high only in IDLE.
REQ-008 SHALL have ports a_time, b_time  in  TIME_W  spike times of operands a and b.
REQ-009 SHALL have ports a_inf, b_inf  in  1  operand carries no spike.
REQ-010 SHALL have port op_set  out  1  set strobe to the temporal operator's latch.
REQ-011 SHALL have ports op_a, op_b  out  1  rising-edge-coded operand lines to the operator.
REQ-012 SHALL have port op_y  in  1  operator output, rising-edge coded.
REQ-013 SHALL have port res_valid  out  1  result held for consumer.
REQ-014 SHALL have port res_ready  in  1  consumer accepts result.
REQ-015 SHALL have port res_time  out  TIME_W  captured spike time of op_y.
REQ-016 SHALL have port res_inf  out  1  op_y did not rise within the window.

Function
REQ-017 SHALL implement FSM states IDLE, SET, RUN, DONE.
REQ-018 IDLE: start_ready=1; on start_valid=1, SHALL latch a_time, b_time, a_inf, b_inf and go to SET next clock.
REQ-019 SET: op_set=1 for exactly PULSE_WIDTH clocks, op_a=op_b=0; then go to RUN with counter k=0.
REQ-020 RUN: k SHALL increment 0..GAMMA_CYCLE_WIDTH-1, one clock per value; op_a=1 iff a_inf=0 and k>=a_time; op_b likewise.
REQ-021 Latched operand time >= GAMMA_CYCLE_WIDTH SHALL be treated as inf.
REQ-022 RUN: op_y SHALL be sampled every clock; on the first clock with op_y=1, res_time SHALL capture k; later samples are ignored.
REQ-023 After the clock with k=GAMMA_CYCLE_WIDTH-1, SHALL go to DONE; res_inf=1 if op_y was never sampled high in RUN.
REQ-024 op_y SHALL be ignored outside RUN.
REQ-025 DONE: res_valid=1, op_a=op_b=op_set=0; res_time and res_inf held stable.
REQ-026 In DONE, res_valid=1 with res_ready=1 SHALL return to IDLE next clock.
REQ-027 res_ready high without res_valid SHALL have no effect.
REQ-028 start_valid outside IDLE SHALL be ignored and not queued.
REQ-029 A new start SHALL be accepted in the clock after the DONE->IDLE transition.
REQ-030 Total latency SHALL be start accept to res_valid = 1+PULSE_WIDTH+GAMMA_CYCLE_WIDTH clocks.
REQ-031 op_set, op_a, op_b SHALL be driven glitch-free: registered outputs, or decoded from registered state only.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, k=0, op_set=op_a=op_b=0, res_valid=0, res_time=0, res_inf=0, and clear latched operands.
REQ-033 Reset asserted mid-SET/RUN/DONE SHALL abort the cycle with no result produced.
REQ-034 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 Defaults, behavioural XOR-style operator model, a_time=3, b_time=7 -> op_set high 8 clocks; op_a rises at k=3, op_b at k=7; res_time=3, res_inf=0 at latency 25.
REQ-036 a_time=5, b_time=5, operator model not-equal (no y edge when equal) -> res_inf=1, res_time=0.
REQ-037 a_inf=1, b_time=15 -> op_a stays 0 for the whole RUN; op_b high only at k=15; res_time=15.
REQ-038 res_ready held 0 for 10 clocks in DONE -> res_valid and result stable; start_valid pulses are ignored; release -> IDLE one clock later.
REQ-039 rst_n pulsed low at RUN k=4 -> all outputs 0 immediately; a fresh start after release completes with correct result.
REQ-040 op_y pulsed high during SET -> ignored; result reflects RUN sampling only.
